// File: rtl/neuron_decay_pkg.sv
// Shared constants for the neuron decay engine: per-neuron decay modes and sweep FSM encoding.
// Saturating arithmetic is selected at build time with NEURON_DECAY_SATURATE_EN.
package neuron_decay_pkg;

   localparam logic [2:0] LIF0  = 3'd0;
   localparam logic [2:0] LIF2  = 3'd1;
   localparam logic [2:0] LIF4  = 3'd2;
   localparam logic [2:0] LIF8  = 3'd3;
   localparam logic [2:0] LIF24 = 3'd4;
   localparam logic [2:0] IZHI  = 3'd5;
   localparam logic [2:0] QUAD  = 3'd6;
   localparam logic [2:0] IDLE  = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/decay_datapath.sv
// Combinational decay step f(mode, v) for one neuron; wraps modulo 2^DATA_W by default,
// saturates IZHI/QUAD/LIF24 when NEURON_DECAY_SATURATE_EN is defined.
module decay_datapath
   import neuron_decay_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [2:0]        i_mode,
   input  logic [DATA_W-1:0] i_v,
   output logic [DATA_W-1:0] o_result
);

   logic [DATA_W-1:0] w_sq_lo;
   logic [DATA_W-1:0] w_x5;
   logic [DATA_W-1:0] w_izhi_min;
   logic [DATA_W-1:0] w_lif24;
   logic [DATA_W-1:0] w_izhi;
   logic [DATA_W-1:0] w_quad;

   assign w_x5       = i_v * DATA_W'(5);
   assign w_izhi_min = w_sq_lo >> 3;

`ifdef NEURON_DECAY_SATURATE_EN
   logic [2*DATA_W-1:0] w_sq_full;
   logic [DATA_W:0]     w_lif24_full;

   assign w_sq_full    = (2*DATA_W)'(i_v) * (2*DATA_W)'(i_v);
   assign w_sq_lo      = w_sq_full[DATA_W-1:0];
   assign w_lif24_full = {1'b0, i_v >> 1} + {1'b0, i_v >> 2};
   assign w_lif24      = w_lif24_full[DATA_W] ? '1 : w_lif24_full[DATA_W-1:0];
   assign w_izhi       = (w_x5 > w_izhi_min) ? '0 : (w_izhi_min - w_x5);
   assign w_quad       = (|w_sq_full[2*DATA_W-1:DATA_W]) ? '1 : w_sq_lo;
`else
   // Low half of a product is independent of the high half, so a DATA_W multiply suffices.
   assign w_sq_lo = i_v * i_v;
   assign w_lif24 = (i_v >> 1) + (i_v >> 2);
   assign w_izhi  = w_izhi_min - w_x5;
   assign w_quad  = w_sq_lo;
`endif

   always_comb begin
      o_result = i_v;
      case (i_mode)
         LIF2:    o_result = i_v >> 1;
         LIF4:    o_result = i_v >> 2;
         LIF8:    o_result = i_v >> 3;
         LIF24:   o_result = w_lif24;
         IZHI:    o_result = w_izhi;
         QUAD:    o_result = w_quad;
         default: o_result = i_v;
      endcase
   end

endmodule

// File: rtl/neuron_decay_engine.sv
// Time-multiplexed membrane decay for a bank of neurons: one FETCH/WRITE pair per neuron per
// time step. Build option NEURON_DECAY_SATURATE_EN selects saturating decay arithmetic.
module neuron_decay_engine
   import neuron_decay_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned N_NEURONS = 16,
   parameter int unsigned IDX_W     = $clog2(N_NEURONS)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_time_step,
   input  logic              i_load_valid,
   input  logic [IDX_W-1:0]  i_load_idx,
   input  logic [DATA_W-1:0] i_load_potential,
   input  logic [2:0]        i_load_mode,
   output logic              o_load_ready,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_potential,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_v;
   logic [2:0]        r_m;
   logic [DATA_W-1:0] r_pot  [N_NEURONS];
   logic [2:0]        r_mode [N_NEURONS];
   logic              r_busy;
   logic              r_done;
   logic              r_overrun;
   logic [DATA_W-1:0] w_result;

   decay_datapath #(
      .DATA_W (DATA_W)
   ) u_datapath (
      .i_mode   (r_m),
      .i_v      (r_v),
      .o_result (w_result)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < N_NEURONS; i++) begin
            r_pot[i]  <= '0;
            r_mode[i] <= LIF0;
         end
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_v       <= '0;
         r_m       <= LIF0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A load on the start edge lands before FETCH reads it.
               if (i_load_valid) begin
                  r_pot[i_load_idx]  <= i_load_potential;
                  r_mode[i_load_idx] <= i_load_mode;
               end
               if (i_time_step) begin
                  r_state <= S_FETCH;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            S_FETCH: begin
               r_v     <= r_pot[r_idx];
               r_m     <= r_mode[r_idx];
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_pot[r_idx] <= w_result;
               if (r_idx == LAST_IDX) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_idx   <= r_idx + 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
         if (r_state != S_IDLE && i_time_step) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_rd_potential = r_pot[i_rd_idx];
   assign o_busy         = r_busy;
   assign o_load_ready   = ~r_busy;
   assign o_done         = r_done;
   assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_neuron_decay_engine.sv
// Directed bench for neuron_decay_engine (N=4): table-driven sweeps plus collision/reset cases.
// Expected IZHI/QUAD values follow NEURON_DECAY_SATURATE_EN when it is defined.
module tb_neuron_decay_engine;
   import neuron_decay_pkg::*;

   localparam int DW = 32;
   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          time_step = 1'b0;
   logic          load_valid = 1'b0;
   logic [IW-1:0] load_idx = '0;
   logic [DW-1:0] load_potential = '0;
   logic [2:0]    load_mode = '0;
   logic          load_ready;
   logic [IW-1:0] rd_idx = '0;
   logic [DW-1:0] rd_potential;
   logic          busy, done, overrun;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   neuron_decay_engine #(
      .DATA_W    (DW),
      .N_NEURONS (N),
      .IDX_W     (IW)
   ) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_time_step      (time_step),
      .i_load_valid     (load_valid),
      .i_load_idx       (load_idx),
      .i_load_potential (load_potential),
      .i_load_mode      (load_mode),
      .o_load_ready     (load_ready),
      .i_rd_idx         (rd_idx),
      .o_rd_potential   (rd_potential),
      .o_busy           (busy),
      .o_done           (done),
      .o_overrun        (overrun)
   );

   typedef struct {
      logic [N-1:0][DW-1:0] pot;
      logic [N-1:0][2:0]    mode;
      logic [N-1:0][DW-1:0] exp;
   } vec_t;

   vec_t vecs [3];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int idx, input logic [DW-1:0] pot, input logic [2:0] mode);
      load_valid     = 1'b1;
      load_idx       = IW'(idx);
      load_potential = pot;
      load_mode      = mode;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic read_chk(input string name, input int idx, input logic [DW-1:0] exp);
      rd_idx = IW'(idx);
      #1;
      chk($sformatf("%s[%0d]", name, idx), rd_potential, exp);
   endtask

   // Pulses time_step for one edge (E0) and watches edges E0..E0+11 for busy/done timing.
   task automatic sweep(input string name, input bit chk_timing);
      int busy_cnt = 0;
      int done_cnt = 0;
      int done_k = -1;
      time_step = 1'b1;
      tick();
      time_step = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            done_k = k;
         end
         if (k < 11) tick();
      end
      if (chk_timing) begin
         chk({name, ".busy_cycles"}, DW'(busy_cnt), DW'(2 * N + 1));
         chk({name, ".done_count"}, DW'(done_cnt), 32'd1);
         chk({name, ".done_edge"}, DW'(done_k), DW'(2 * N));
      end
   endtask

   initial begin
      vecs[0].pot  = {32'd100, 32'd100, 32'd100, 32'd100};
      vecs[0].mode = {LIF8, LIF0, LIF24, LIF2};
      vecs[0].exp  = {32'd12, 32'd100, 32'd75, 32'd50};
      vecs[1].pot  = {32'd1000, 32'hFFFF_FFFF, 32'h0001_0000, 32'd8};
      vecs[1].mode = {LIF4, LIF24, QUAD, IZHI};
`ifdef NEURON_DECAY_SATURATE_EN
      vecs[1].exp  = {32'd250, 32'hBFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
`else
      vecs[1].exp  = {32'd250, 32'hBFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFE0};
`endif
      vecs[2].pot  = {32'hFFFF_FFFF, 32'd100, 32'd3, 32'd7};
      vecs[2].mode = {LIF8, IZHI, QUAD, IDLE};
      vecs[2].exp  = {32'h1FFF_FFFF, 32'd750, 32'd9, 32'd7};

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < N; i++) read_chk("reset.pot", i, '0);
      chk("reset.busy", DW'(busy), '0);
      chk("reset.done", DW'(done), '0);
      chk("reset.overrun", DW'(overrun), '0);
      chk("reset.load_ready", DW'(load_ready), 32'd1);

      // Table-driven sweeps
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < N; i++) load(i, vecs[v].pot[i], vecs[v].mode[i]);
         sweep($sformatf("vec%0d", v), v == 0);
         for (int i = 0; i < N; i++) read_chk($sformatf("vec%0d.pot", v), i, vecs[v].exp[i]);
      end

      // Repeated LIF2 decay
      load(0, 32'd1000, LIF2);
      sweep("rep1", 1'b0);
      read_chk("rep.sweep1", 0, 32'd500);
      sweep("rep2", 1'b0);
      read_chk("rep.sweep2", 0, 32'd250);
      sweep("rep3", 1'b0);
      read_chk("rep.sweep3", 0, 32'd125);

      // Collisions: load+start on the same idle edge, then a load and a time_step mid-sweep
      for (int i = 1; i < N; i++) load(i, 32'd5, LIF0);
      chk("coll.overrun_pre", DW'(overrun), '0);
      load_valid     = 1'b1;
      load_idx       = 2'd0;
      load_potential = 32'd64;
      load_mode      = LIF2;
      time_step      = 1'b1;
      tick();
      load_valid = 1'b0;
      time_step  = 1'b0;
      chk("coll.busy", DW'(busy), 32'd1);
      chk("coll.load_ready", DW'(load_ready), '0);
      tick();
      load(3, 32'd555, LIF0);
      time_step = 1'b1;
      tick();
      time_step = 1'b0;
      begin
         int guard = 0;
         while (busy && guard < 40) begin
            tick();
            guard++;
         end
         chk("coll.finish_in_budget", DW'(busy), '0);
      end
      chk("coll.overrun", DW'(overrun), 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         if (busy) chk("coll.no_restart", DW'(busy), '0);
      end
      chk("coll.idle_after", DW'(busy), '0);
      read_chk("coll.pot", 0, 32'd32);
      read_chk("coll.pot", 3, 32'd5);

      // Reset mid-sweep: rst sampled at E0+3
      load(0, 32'd1000, LIF2);
      time_step = 1'b1;
      tick();
      time_step = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.busy", DW'(busy), '0);
      chk("rstmid.done", DW'(done), '0);
      chk("rstmid.overrun", DW'(overrun), '0);
      for (int i = 0; i < N; i++) read_chk("rstmid.pot", i, '0);
      begin
         int seen_done = 0;
         for (int k = 0; k < 10; k++) begin
            tick();
            if (done || busy) seen_done++;
         end
         chk("rstmid.quiet", DW'(seen_done), '0);
      end
      read_chk("rstmid.pot_after", 0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
